cs_final_reduce: RTL and testbench

//   Output stage after the last main_round of the carry-save modular multiplier.

---
 rtl/cs_final_reduce_if.sv | 24 ++
 rtl/cs_final_reduce.sv | 138 +++++++++++++
 tb/tb_cs_final_reduce.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cs_final_reduce_if.sv
// Handshake bundle for the carry-save final reduction stage:
// the (p, q, m) request channel plus the r response channel.
interface cs_final_reduce_if #(
    parameter int N = 256
);
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   p;
    logic [N:0]   q;
    logic [N-1:0] m;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] r;

    modport master (
        output in_valid, p, q, m, out_ready,
        input  in_ready, out_valid, r
    );

    modport slave (
        input  in_valid, p, q, m, out_ready,
        output in_ready, out_valid, r
    );
endinterface

// File: rtl/cs_final_reduce.sv
// Chunk-serial resolution of a carry-save pair (p, q) into the canonical residue
// (p + q) mod m: one carry-propagate pass, then up to three conditional subtractions of m.
module cs_final_reduce #(
    parameter int N = 256,
    parameter int W = 64
) (
    input  logic             clk,
    input  logic             rst,
    cs_final_reduce_if.slave bus
);
    localparam int C  = (N + 2 + W - 1) / W;
    localparam int CW = C * W;
    localparam int KW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] s_r;
    logic [CW-1:0] q_r;
    logic [CW-1:0] m_r;
    logic [CW-1:0] d_r;
    logic [KW-1:0] k_r;
    logic [1:0]    j_r;
    logic          cy_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [N-1:0]  r_r;

    logic [W-1:0]  s_chunk_s;
    logic [W-1:0]  q_chunk_s;
    logic [W-1:0]  m_chunk_s;
    logic [W:0]    sum_s;
    logic [W:0]    dif_s;
    logic [CW-1:0] d_next_s;
    logic          last_s;

    // Chunk datapath: add for the carry pass, subtract-with-borrow for the reduction passes.
    always_comb begin
        s_chunk_s = s_r[k_r*W +: W];
        q_chunk_s = q_r[k_r*W +: W];
        m_chunk_s = m_r[k_r*W +: W];
        sum_s     = {1'b0, s_chunk_s} + {1'b0, q_chunk_s} + {{W{1'b0}}, cy_r};
        // Bit W of the (W+1)-bit difference is the outgoing borrow.
        dif_s     = {1'b0, s_chunk_s} - {1'b0, m_chunk_s} - {{W{1'b0}}, cy_r};
        d_next_s  = d_r;
        d_next_s[k_r*W +: W] = dif_s[W-1:0];
        last_s    = (k_r == KW'(C - 1));
    end

    // Control FSM and all state registers; outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            s_r         <= {CW{1'b0}};
            q_r         <= {CW{1'b0}};
            m_r         <= {CW{1'b0}};
            d_r         <= {CW{1'b0}};
            k_r         <= {KW{1'b0}};
            j_r         <= 2'd0;
            cy_r        <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            r_r         <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        s_r        <= CW'(bus.p);
                        q_r        <= CW'(bus.q);
                        m_r        <= CW'(bus.m);
                        k_r        <= {KW{1'b0}};
                        cy_r       <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= ADD;
                    end
                end
                ADD: begin
                    s_r[k_r*W +: W] <= sum_s[W-1:0];
                    cy_r            <= sum_s[W];
                    if (last_s) begin
                        k_r     <= {KW{1'b0}};
                        cy_r    <= 1'b0;
                        j_r     <= 2'd0;
                        state_r <= SUB;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                SUB: begin
                    d_r  <= d_next_s;
                    cy_r <= dif_s[W];
                    if (last_s) begin
                        k_r  <= {KW{1'b0}};
                        cy_r <= 1'b0;
                        if (dif_s[W]) begin
                            r_r         <= s_r[N-1:0];
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            s_r <= d_next_s;
                            j_r <= j_r + 2'd1;
                            // Third successful subtraction: the precondition guarantees S < m now.
                            if (j_r == 2'd2) begin
                                r_r         <= d_next_s[N-1:0];
                                out_valid_r <= 1'b1;
                                state_r     <= DONE;
                            end
                        end
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.r         = r_r;
endmodule

// File: tb/tb_cs_final_reduce.sv
// Directed and random checks of cs_final_reduce at N=8, W=4 (three chunks per pass),
// with a scoreboard of expected residues and latencies.
module tb_cs_final_reduce;
    localparam int N = 8;
    localparam int W = 4;
    localparam int C = 3;

    typedef struct {
        int r;
        int lat;
        int acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    logic prev_ov;

    cs_final_reduce_if #(.N(N)) bus ();

    cs_final_reduce #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int p, input int q, input int m, input int acc);
        exp_t e;
        int   s;
        int   passes;
        s      = p + q;
        passes = s / m + 1;
        if (passes > 3) passes = 3;
        e.r    = (s < 4 * m) ? (s % m) : ((s - 3 * m) & 255);
        e.lat  = C * (1 + passes);
        e.acc  = acc;
        return e;
    endfunction

    // Scoreboard: push on accept, check latency/value on rise, hold stability, pop on handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(int'(bus.p), int'(bus.q), int'(bus.m), cyc + 1));
            if (bus.out_valid && !prev_ov) begin
                check("out_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    check("r_value", int'(bus.r), sb[0].r);
                    check("latency", cyc - sb[0].acc, sb[0].lat);
                end
            end else if (bus.out_valid && prev_ov && sb.size() > 0) begin
                check("r_held", int'(bus.r), sb[0].r);
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0)
                void'(sb.pop_front());
            prev_ov = bus.out_valid;
        end
    end

    task automatic present(input int p, input int q, input int m);
        int k;
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_timeout", int'(k < 40), 1);
        bus.p        = 9'(p);
        bus.q        = 9'(q);
        bus.m        = 8'(m);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int hs);
        int k;
        k = 0;
        while (!(bus.out_valid && (bus.out_ready || !hs)) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("out_timeout", int'(k < 60), 1);
    endtask

    task automatic run_txn(input int p, input int q, input int m);
        present(p, q, m);
        wait_out(1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   m_v;
        int   s_v;
        int   p_v;
        int   lo;
        int   hi;
        int   sent;
        int   k;
        cyc           = 0;
        n_cmp         = 0;
        n_bad         = 0;
        prev_ov       = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.p         = 9'd0;
        bus.q         = 9'd0;
        bus.m         = 8'd1;

        // Reset state
        #1;
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_r", int'(bus.r), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_held", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready_before_edge", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        check("rel_in_ready_after_edge", int'(bus.in_ready), 1);

        // Directed cases 1-4
        run_txn(300, 200, 251);
        run_txn(0, 0, 7);
        run_txn(511, 288, 200);
        run_txn(100, 151, 251);

        // Backpressure on case 1
        bus.out_ready = 1'b0;
        present(300, 200, 251);
        wait_out(0);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_r", int'(bus.r), 249);
            check("bp_in_ready", int'(bus.in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", int'(bus.out_valid), 0);
        check("bp_release_in_ready", int'(bus.in_ready), 1);

        // Reset during the second SUB pass of case 3
        present(511, 288, 200);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_r", int'(bus.r), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) k++;
        end
        check("no_spurious_out", k, 0);
        @(posedge clk); #1;
        run_txn(300, 200, 251);

        // Back-to-back random transactions with in_valid held high
        sent = 0;
        k    = 0;
        m_v  = $urandom_range(1, 255);
        hi   = (4 * m_v - 1 < 1022) ? 4 * m_v - 1 : 1022;
        s_v  = $urandom_range(0, hi);
        lo   = (s_v > 511) ? s_v - 511 : 0;
        hi   = (s_v < 511) ? s_v : 511;
        p_v  = $urandom_range(lo, hi);
        bus.p = 9'(p_v); bus.q = 9'(s_v - p_v); bus.m = 8'(m_v);
        bus.in_valid = 1'b1;
        while (sent < 20 && k < 2000) begin
            @(negedge clk);
            k++;
            if (bus.in_ready) begin
                @(posedge clk); #1;
                sent++;
                m_v = $urandom_range(1, 255);
                hi  = (4 * m_v - 1 < 1022) ? 4 * m_v - 1 : 1022;
                s_v = $urandom_range(0, hi);
                lo  = (s_v > 511) ? s_v - 511 : 0;
                hi  = (s_v < 511) ? s_v : 511;
                p_v = $urandom_range(lo, hi);
                bus.p = 9'(p_v); bus.q = 9'(s_v - p_v); bus.m = 8'(m_v);
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_sent", sent, 20);
        k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
